// File: rtl/producto_bcd_seq.sv
// producto_bcd_seq
//   Sequential double-dabble converter sitting behind the Booth multiplier.
//   Takes a signed two's-complement product and turns it into a sign flag
//   plus packed BCD magnitude digits for the display stage. Only one
//   conversion is in flight at a time. Each of the W bit iterations takes
//   two cycles: an add-3 adjust followed by a shift.
//
// Ports
//   clk      in   1         clock, rising edge
//   rst      in   1         asynchronous reset, active high
//   start    in   1         product valid strobe; accepted only in IDLE
//   product  in   W         signed product, sampled when start is accepted
//   busy     out  1         conversion in progress (state != IDLE)
//   done     out  1         one-cycle pulse: sign/bcd updated this cycle
//   sign     out  1         1 = product was negative
//   bcd      out  4*DIGITS  magnitude, digit 0 in bcd[3:0]
module producto_bcd_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [W-1:0]          product,
   output logic                  busy,
   output logic                  done,
   output logic                  sign,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, FINISH} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    bin_q, bin_d;
   logic [BW-1:0]   bcd_r_q, bcd_r_d;
   logic            sign_r_q, sign_r_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            sign_q, sign_d;
   logic [BW-1:0]   bcd_q, bcd_d;

   logic [BW-1:0]   bcd_adj;
   logic [W-1:0]    product_abs;

   // Two's-complement magnitude kept W bits wide and unsigned, so the most
   // negative value maps to 2**(W-1) without overflowing.
   assign product_abs = product[W-1] ? ((~product) + W'(1)) : product;

   // Add-3 correction on every nibble in parallel: a nibble >= 5 would
   // become >= 10 after the following shift, so pre-bias it to carry out.
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign bcd_adj[4*i +: 4] = (bcd_r_q[4*i +: 4] >= 4'd5) ?
                                 (bcd_r_q[4*i +: 4] + 4'd3) :
                                  bcd_r_q[4*i +: 4];
   end

   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      bcd_r_d  = bcd_r_q;
      sign_r_d = sign_r_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      sign_d   = sign_q;
      bcd_d    = bcd_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               sign_r_d = product[W-1];
               bin_d    = product_abs;
               bcd_r_d  = '0;
               cnt_d    = CW'(W);
               state_d  = ADJUST;
            end
         end
         ADJUST: begin
            bcd_r_d = bcd_adj;
            state_d = SHIFT;
         end
         SHIFT: begin
            bcd_r_d = {bcd_r_q[BW-2:0], bin_q[W-1]};
            bin_d   = {bin_q[W-2:0], 1'b0};
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? FINISH : ADJUST;
         end
         FINISH: begin
            bcd_d   = bcd_r_q;
            sign_d  = sign_r_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Registered so busy tracks the state register exactly.
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         bin_q    <= '0;
         bcd_r_q  <= '0;
         sign_r_q <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sign_q   <= 1'b0;
         bcd_q    <= '0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_r_q  <= bcd_r_d;
         sign_r_q <= sign_r_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sign_q   <= sign_d;
         bcd_q    <= bcd_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sign = sign_q;
   assign bcd  = bcd_q;

endmodule
